// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch controller: PC width, default boot PC
// and the FSM state encoding.
package fetch_pkg;

   localparam int PC_W = 32;
   localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0040_0000;

   typedef enum logic [1:0] {
      BOOT     = 2'd0,
      RUN      = 2'd1,
      MEM_WAIT = 2'd2,
      REDIRECT = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Pipeline-side bundle of fetch_ctrl: hazard/redirect/memory inputs and PC control outputs.
// Optional macro FETCH_CTRL_PERF_EN adds the two performance-counter outputs.
interface fetch_ctrl_if;
   import fetch_pkg::*;

   logic            stall_in;
   logic            branch_taken;
   logic [PC_W-1:0] branch_target;
   logic            jump_taken;
   logic [PC_W-1:0] jump_target;
   logic            mem_ready;

   logic            PC_reg_enable;
   logic            mux_PC_flag;
   logic [PC_W-1:0] jump_address;
   logic            Readmem;
   logic            IFID_flush;
   logic [PC_W-1:0] boot_pc;
   logic [1:0]      state_dbg;
`ifdef FETCH_CTRL_PERF_EN
   logic [31:0]     perf_stall_cnt;
   logic [31:0]     perf_redir_cnt;
`endif

   modport master (
      output stall_in, branch_taken, branch_target, jump_taken, jump_target, mem_ready,
      input  PC_reg_enable, mux_PC_flag, jump_address, Readmem, IFID_flush, boot_pc, state_dbg
`ifdef FETCH_CTRL_PERF_EN
      , input perf_stall_cnt, perf_redir_cnt
`endif
   );

   modport slave (
      input  stall_in, branch_taken, branch_target, jump_taken, jump_target, mem_ready,
      output PC_reg_enable, mux_PC_flag, jump_address, Readmem, IFID_flush, boot_pc, state_dbg
`ifdef FETCH_CTRL_PERF_EN
      , output perf_stall_cnt, perf_redir_cnt
`endif
   );

endinterface

// File: rtl/sat_counter32.sv
// 32-bit event counter that sticks at all-ones; used for the fetch performance counters.
module sat_counter32
   import fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   output logic [31:0] count
);

   logic [31:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != 32'hFFFF_FFFF)) count_d = count_q + 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch control FSM: PC load/hold, redirect muxing and IF/ID squash.
// Define FETCH_CTRL_PERF_EN to add saturating stall/redirect performance counters.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
)(
   input  logic        clk,
   input  logic        rst,
   fetch_ctrl_if.slave bus
);

   fetch_state_e    state_q, state_d;
   logic            pend_valid_q, pend_valid_d;
   logic [PC_W-1:0] pend_target_q, pend_target_d;
   logic [PC_W-1:0] jump_address_q, jump_address_d;

   logic            redir_req;
   logic [PC_W-1:0] redir_tgt;
   logic            pc_hold;
   logic            apply_redir;

   // Branch resolves in EX and is older than an ID jump, so it wins.
   assign redir_req = bus.branch_taken | bus.jump_taken;
   assign redir_tgt = bus.branch_taken ? bus.branch_target : bus.jump_target;

   // NOTE: every variable gets a default before the case so no path infers a latch.
   always_comb begin
      state_d        = state_q;
      pend_valid_d   = pend_valid_q;
      pend_target_d  = pend_target_q;
      jump_address_d = jump_address_q;
      pc_hold        = 1'b1;
      apply_redir    = 1'b0;

      case (state_q)
         BOOT: state_d = RUN;

         RUN: begin
            if (bus.mem_ready) begin
               if (redir_req) begin
                  apply_redir    = 1'b1;
                  pc_hold        = 1'b0;
                  jump_address_d = redir_tgt;
               end else begin
                  pc_hold = bus.stall_in;
               end
            end else begin
               state_d = MEM_WAIT;
               if (redir_req) begin
                  pend_valid_d  = 1'b1;
                  pend_target_d = redir_tgt;
               end
            end
         end

         MEM_WAIT: begin
            // A later branch replaces the pending target; a later jump is younger and dropped.
            if (bus.branch_taken) begin
               pend_valid_d  = 1'b1;
               pend_target_d = bus.branch_target;
            end else if (bus.jump_taken && !pend_valid_q) begin
               pend_valid_d  = 1'b1;
               pend_target_d = bus.jump_target;
            end
            if (bus.mem_ready) state_d = pend_valid_d ? REDIRECT : RUN;
         end

         REDIRECT: begin
            apply_redir    = 1'b1;
            pc_hold        = 1'b0;
            jump_address_d = bus.branch_taken ? bus.branch_target : pend_target_q;
            pend_valid_d   = 1'b0;
            state_d        = RUN;
         end

         default: state_d = BOOT;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= BOOT;
         pend_valid_q   <= 1'b0;
         pend_target_q  <= '0;
         jump_address_q <= '0;
      end else begin
         state_q        <= state_d;
         pend_valid_q   <= pend_valid_d;
         pend_target_q  <= pend_target_d;
         jump_address_q <= jump_address_d;
      end
   end

   assign bus.PC_reg_enable = pc_hold;
   assign bus.mux_PC_flag   = apply_redir;
   assign bus.IFID_flush    = apply_redir;
   assign bus.jump_address  = jump_address_d;
   assign bus.Readmem       = ~rst;
   assign bus.boot_pc       = RESET_PC;
   assign bus.state_dbg     = state_q;

`ifdef FETCH_CTRL_PERF_EN
   logic [31:0] stall_cnt, redir_cnt;

   sat_counter32 u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (pc_hold && (state_q != BOOT)),
      .count (stall_cnt)
   );

   sat_counter32 u_redir_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (apply_redir),
      .count (redir_cnt)
   );

   assign bus.perf_stall_cnt = stall_cnt;
   assign bus.perf_redir_cnt = redir_cnt;
`endif

endmodule
